// File: rtl/io_wb_master.sv
// Wishbone classic single-transfer initiator: valid/ready command in, one bus cycle, valid/ready response out.
// Optional ack timeout is enabled with the IO_WBM_TIMEOUT_EN macro.
module io_wb_master #(
  parameter int ADR_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [31:0]      cmd_dat,
  input  logic [3:0]       cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("io_wb_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
`ifdef IO_WBM_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TIMEOUT_CYCLES - 1);
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef IO_WBM_TIMEOUT_EN
      err_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef IO_WBM_TIMEOUT_EN
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef IO_WBM_TIMEOUT_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          sel_d       = cmd_sel;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
`ifdef IO_WBM_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so an ack on the limit cycle still completes normally.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = we_q ? 32'd0 : wb_dat_i;
          rsp_valid_d = 1'b1;
`ifdef IO_WBM_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = RESP;
        end
`ifdef IO_WBM_TIMEOUT_EN
        else if (cnt_q == ToLast) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = 32'd0;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d       = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
`ifdef IO_WBM_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_io_wb_master.sv
// Directed self-checking bench for io_wb_master with a small IO register file responder.
// Covers the IO_WBM_TIMEOUT_EN build and the default build with matching scenarios.
module tb_io_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic        wb_ack_i;

  int checks = 0;
  int fails  = 0;

  // Responder controls: silent ignores the bus and uses manualAck; trailing holds ack one extra cycle.
  logic        silent    = 1'b0;
  logic        trailing  = 1'b0;
  logic        manualAck = 1'b0;
  logic        ackQ      = 1'b0;
  logic [31:0] rdatQ     = '0;
  logic [31:0] mem0      = 32'h0000_0000;
  logic [31:0] mem4      = 32'h0001_2345;

  io_wb_master #(.ADR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mergeSel(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !ackQ) begin
      if (wb_we_o && !silent) begin
        if (wb_adr_o == 32'h0) mem0 <= mergeSel(mem0, wb_dat_o, wb_sel_o);
        if (wb_adr_o == 32'h4) mem4 <= mergeSel(mem4, wb_dat_o, wb_sel_o);
      end
      rdatQ <= (wb_adr_o == 32'h0) ? mem0 : (wb_adr_o == 32'h4) ? mem4 : 32'h0;
    end
    ackQ <= !silent && wb_cyc_o && wb_stb_o && (trailing || !ackQ);
  end

  assign wb_dat_i = rdatQ;
  assign wb_ack_i = silent ? manualAck : ackQ;

  task automatic issueCmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = 32'hFFFF_FFF0; cmd_dat = 32'hBAD0_BAD0; cmd_sel = ~sel;
  endtask

  task automatic countCyc(input int limit, output int n);
    n = 0;
    while (wb_cyc_o === 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic ackRsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [73:0] got;
    repeat (2) @(negedge clk);
    got = {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
    checks++;
    if (got !== 74'h0) begin
      fails++; $display("[TB] FAIL reset_wb: got %h expected 0", got);
    end
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err} !== 3'b100) begin
      fails++; $display("[TB] FAIL reset_hs: got %b expected 100", {cmd_ready, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_dat !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_rsp_dat: got %h expected 0", rsp_dat);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int n;
    issueCmd(1'b1, 32'h0, 32'h000A_5A5A, 4'hF);
    checks++;
    if ({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cmd_ready} !== {1'b1, 32'h0, 32'h000A_5A5A, 4'hF, 1'b0}) begin
      fails++; $display("[TB] FAIL write_bus: got we=%b adr=%h dat=%h sel=%h rdy=%b expected 1 0 000a5a5a f 0",
                        wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cmd_ready);
    end
    countCyc(50, n);
    checks++;
    if (n !== 2) begin
      fails++; $display("[TB] FAIL write_cyc_len: got %0d expected 2", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0}) begin
      fails++; $display("[TB] FAIL write_rsp: got v=%b e=%b d=%h expected 1 0 0", rsp_valid, rsp_err, rsp_dat);
    end
    ackRsp();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      fails++; $display("[TB] FAIL write_handshake: got v=%b rdy=%b expected 0 1", rsp_valid, cmd_ready);
    end
    issueCmd(1'b0, 32'h0, 32'h0, 4'hF);
    countCyc(50, n);
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h000A_5A5A}) begin
      fails++; $display("[TB] FAIL readback: got v=%b e=%b d=%h expected 1 0 000a5a5a", rsp_valid, rsp_err, rsp_dat);
    end
    ackRsp();
  endtask

  task automatic test_trailing_ack();
    int n;
    int extra;
    trailing = 1'b1;
    issueCmd(1'b0, 32'h10, 32'h0, 4'hF);
    countCyc(50, n);
    checks++;
    if ({rsp_valid, rsp_dat} !== {1'b1, 32'h0}) begin
      fails++; $display("[TB] FAIL unmapped_read: got v=%b d=%h expected 1 0", rsp_valid, rsp_dat);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_dat, wb_cyc_o} !== {1'b1, 32'h0, 1'b0}) begin
      fails++; $display("[TB] FAIL trailing_hold: got v=%b d=%h cyc=%b expected 1 0 0", rsp_valid, rsp_dat, wb_cyc_o);
    end
    ackRsp();
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0) begin
      fails++; $display("[TB] FAIL trailing_no_rsp: got %0d busy cycles expected 0", extra);
    end
    trailing = 1'b0;
  endtask

  task automatic test_sel_zero();
    int n;
    issueCmd(1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_sel_o} !== 6'b110000) begin
      fails++; $display("[TB] FAIL sel0_bus: got cyc=%b stb=%b sel=%h expected 1 1 0", wb_cyc_o, wb_stb_o, wb_sel_o);
    end
    countCyc(50, n);
    checks++;
    if ({n == 2, rsp_valid} !== 2'b11) begin
      fails++; $display("[TB] FAIL sel0_done: got len=%0d v=%b expected 2 1", n, rsp_valid);
    end
    ackRsp();
  endtask

  task automatic test_backpressure();
    int n;
    issueCmd(1'b0, 32'h4, 32'h0, 4'hF);
    countCyc(50, n);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0; cmd_dat = 32'hFFFF_FFFF; cmd_sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, wb_cyc_o, rsp_dat} !== {3'b100, 32'h0001_2345}) begin
        fails++; $display("[TB] FAIL backpressure_%0d: got v=%b rdy=%b cyc=%b d=%h expected 1 0 0 00012345",
                          i, rsp_valid, cmd_ready, wb_cyc_o, rsp_dat);
      end
      @(negedge clk);
    end
    ackRsp();
    checks++;
    if ({rsp_valid, cmd_ready, wb_cyc_o} !== 3'b010) begin
      fails++; $display("[TB] FAIL bp_release: got v=%b rdy=%b cyc=%b expected 0 1 0", rsp_valid, cmd_ready, wb_cyc_o);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad;
    silent = 1'b1;
    issueCmd(1'b0, 32'h4, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      fails++; $display("[TB] FAIL mid_cyc_pre: got %b expected 1", wb_cyc_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin
      fails++; $display("[TB] FAIL mid_async_drop: got cyc=%b stb=%b expected 0 0", wb_cyc_o, wb_stb_o);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({cmd_ready, rsp_valid, wb_cyc_o} !== 3'b100) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("[TB] FAIL mid_after: got %0d bad cycles expected 0", bad);
    end
  endtask

`ifdef IO_WBM_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    issueCmd(1'b0, 32'h0, 32'h0, 4'hF);
    countCyc(50, n);
    checks++;
    if (n !== 8) begin
      fails++; $display("[TB] FAIL timeout_len: got %0d expected 8", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b1, 32'h0}) begin
      fails++; $display("[TB] FAIL timeout_rsp: got v=%b e=%b d=%h expected 1 1 0", rsp_valid, rsp_err, rsp_dat);
    end
    ackRsp();
    issueCmd(1'b0, 32'h0, 32'h0, 4'hF);
    repeat (7) @(negedge clk);
    manualAck = 1'b1;
    @(negedge clk);
    manualAck = 1'b0;
    checks++;
    if ({wb_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'h000A_5A5A}) begin
      fails++; $display("[TB] FAIL ack_on_limit: got cyc=%b v=%b e=%b d=%h expected 0 1 0 000a5a5a",
                        wb_cyc_o, rsp_valid, rsp_err, rsp_dat);
    end
    ackRsp();
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    issueCmd(1'b0, 32'h4, 32'h0, 4'hF);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wb_cyc_o !== 1'b1 || rsp_valid !== 1'b0) bad++;
      if (i == 999) manualAck = 1'b1;
      @(negedge clk);
    end
    manualAck = 1'b0;
    checks++;
    if (bad !== 0) begin
      fails++; $display("[TB] FAIL wait_forever: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if ({wb_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'h0001_2345}) begin
      fails++; $display("[TB] FAIL late_ack: got cyc=%b v=%b e=%b d=%h expected 0 1 0 00012345",
                        wb_cyc_o, rsp_valid, rsp_err, rsp_dat);
    end
    ackRsp();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_trailing_ack();
    test_sel_zero();
    test_backpressure();
    test_reset_mid();
`ifdef IO_WBM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
